clint: RTL and testbench
========================

CLINT -- requirements
Module: clint

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 64'h0000_0000_0200_0000, base address of the register window.
REQ-002 SHALL have parameter TICK_DIV, default 1, clk cycles per mtime increment; used only when CLINT_PRESCALE_EN is defined.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-007 SHALL have port req_wen  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  XLEN (64)  byte address, 8-byte aligned.
REQ-009 SHALL have port req_wdata  input  64  write data.
REQ-010 SHALL have port req_wmask  input  8  byte-lane write enables.
REQ-011 SHALL have port resp_valid  output  1  response present.
REQ-012 SHALL have port resp_ready  input  1  response consumed when resp_valid && resp_ready.
REQ-013 SHALL have port resp_rdata  output  64  read data; 0 for writes and errors.
REQ-014 SHALL have port resp_err  output  1  unmapped address.
REQ-015 SHALL have port msip  output  1  machine software interrupt to the CSR block.
REQ-016 SHALL have port mtip  output  1  machine timer interrupt to the CSR block.

Function
REQ-017 SHALL map msip register at ADDR_BASE+0x0000 (bit 0 only, other bits read 0), mtimecmp at ADDR_BASE+0x4000, mtime at ADDR_BASE+0xBFF8, all 64-bit.
REQ-018 SHALL implement a two-state FSM: IDLE (req_ready=1) and RESP (req_ready=0, resp_valid=1); IDLE->RESP on accept, RESP->IDLE on resp_valid && resp_ready.
REQ-019 SHALL give a response exactly one cycle after accept and hold resp_rdata/resp_err stable while in RESP.
REQ-020 SHALL perform writes in the accept cycle, byte lanes gated by req_wmask; a write with req_wmask=0 has no effect but still responds.
REQ-021 SHALL capture read data from register values at the accept edge.
REQ-022 SHALL respond to any unmapped address with resp_err=1, resp_rdata=0, and no state change.
REQ-023 SHALL increment mtime by 1 per tick, wrapping 64'hFFFF_FFFF_FFFF_FFFF -> 0.
REQ-024 SHALL, when a mtime write and a tick coincide, store the written bytes and increment unwritten bytes normally; write wins on written lanes.
REQ-025 SHALL drive msip = msip register bit 0.
REQ-026 SHALL drive mtip = (mtime >= mtimecmp), unsigned, combinational from registers; it deasserts the cycle after mtimecmp is written above mtime.

Reset
REQ-027 SHALL on rst low asynchronously set mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip reg=0, prescaler=0, FSM=IDLE.
REQ-028 SHALL hold during reset req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, msip=0, mtip=0.
REQ-029 SHALL, on reset asserted mid-transaction, drop the pending response without delivering it.

Configuration
REQ-030 SHALL with CLINT_PRESCALE_EN defined tick once every TICK_DIV cycles via a counter that counts 0..TICK_DIV-1; the counter is not affected by mtime writes.
REQ-031 SHALL without CLINT_PRESCALE_EN tick every clk cycle and contain no prescaler logic.

Verification
REQ-032 SHALL cover: after reset, read ADDR_BASE+0xBFF8 -> resp_err=0, rdata equals the number of cycles since reset release (macro off); mtip=0.
REQ-033 SHALL cover: write mtimecmp=100 (wmask 8'hFF), run -> mtip rises in the cycle mtime reaches 100; write mtimecmp=2^64-1 -> mtip=0 the next cycle.
REQ-034 SHALL cover: write 1 to ADDR_BASE+0x0000 -> msip=1 the next cycle; write 0 -> msip=0; read back returns 0x1 / 0x0.
REQ-035 SHALL cover: write mtime=64'hFFFF_FFFF_FFFF_FFFE -> wraps to 0 two ticks later; byte-masked write wmask=8'h01 data 0x55 changes only byte 0.
REQ-036 SHALL cover: read ADDR_BASE+0x1000 -> resp_err=1, rdata=0; hold resp_ready=0 for 5 cycles -> resp_valid and data stay stable and req_ready=0.
REQ-037 SHALL cover: CLINT_PRESCALE_EN defined with TICK_DIV=4 -> mtime advances by 1 every 4 cycles; asserting rst mid-RESP clears resp_valid immediately.

Source files
------------

// File: rtl/clint.sv
// clint: machine timer (mtime/mtimecmp) and software interrupt (msip) behind a one-outstanding request port.
// Define CLINT_PRESCALE_EN to advance mtime once every TICK_DIV clocks instead of every clock.
module clint #(
  parameter logic [63:0] ADDR_BASE = 64'h0000_0000_0200_0000,
  parameter int          TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        msip,
  output logic        mtip
);
  // state   | meaning
  // ST_IDLE | waiting for a request (req_ready once out of reset)
  // ST_RESP | response held until resp_ready
  typedef enum logic {ST_IDLE, ST_RESP} state_t;

  state_t      r_state;
  logic        r_req_ready;
  logic [63:0] r_rdata;
  logic        r_err;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;

  logic        w_accept;
  logic        w_wr;
  logic        w_sel_msip;
  logic        w_sel_cmp;
  logic        w_sel_time;
  logic        w_hit;
  logic        w_tick;
  logic [63:0] w_bmask;
  logic [63:0] w_rd_mux;
  logic [63:0] w_time_inc;

  assign w_accept   = req_valid && r_req_ready;
  assign w_wr       = w_accept && req_wen;
  assign w_sel_msip = (req_addr == ADDR_BASE);
  assign w_sel_cmp  = (req_addr == ADDR_BASE + 64'h4000);
  assign w_sel_time = (req_addr == ADDR_BASE + 64'hBFF8);
  assign w_hit      = w_sel_msip || w_sel_cmp || w_sel_time;

  always_comb begin
    w_bmask = '0;
    for (int i = 0; i < 8; i++) begin
      w_bmask[i*8 +: 8] = {8{req_wmask[i]}};
    end
  end

  always_comb begin
    w_rd_mux = '0;
    if (w_sel_msip)      w_rd_mux = {63'b0, r_msip};
    else if (w_sel_cmp)  w_rd_mux = r_mtimecmp;
    else if (w_sel_time) w_rd_mux = r_mtime;
  end

`ifdef CLINT_PRESCALE_EN
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] r_presc;

  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  // Free-running divider; mtime writes never disturb its phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PW'(1);
  end
`else
  assign w_tick = 1'b1;
`endif

  assign w_time_inc = r_mtime + {63'b0, w_tick};

  // Written lanes take the new data; the rest keep counting so a coincident tick is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_msip     <= 1'b0;
    end else begin
      if (w_wr && w_sel_time) r_mtime <= (req_wdata & w_bmask) | (w_time_inc & ~w_bmask);
      else                    r_mtime <= w_time_inc;
      if (w_wr && w_sel_cmp)  r_mtimecmp <= (req_wdata & w_bmask) | (r_mtimecmp & ~w_bmask);
      if (w_wr && w_sel_msip && req_wmask[0]) r_msip <= req_wdata[0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_state     <= ST_RESP;
            r_req_ready <= 1'b0;
            r_err       <= !w_hit;
            r_rdata     <= (req_wen || !w_hit) ? 64'b0 : w_rd_mux;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rdata     <= '0;
            r_err       <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign msip       = r_msip;
  assign mtip       = (r_mtime >= r_mtimecmp);
endmodule

// File: tb/tb_clint.sv
// tb_clint: directed requests with a response scoreboard, plus a cycle-accurate timer reference model.
module tb_clint;
`ifdef CLINT_PRESCALE_EN
  localparam int TD = 4;
`else
  localparam int TD = 1;
`endif
  localparam logic [63:0] BASE  = 64'h0000_0000_0200_0000;
  localparam logic [63:0] A_MSIP = BASE;
  localparam logic [63:0] A_CMP  = BASE + 64'h4000;
  localparam logic [63:0] A_TIME = BASE + 64'hBFF8;
  localparam int EXPL = 0, MDL = 1, CYC = 2;
  localparam int CYC_MODE = (TD == 1) ? CYC : MDL;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        msip, mtip;

  clint #(.ADDR_BASE(BASE), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .msip(msip), .mtip(mtip)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    string       name;
  } exp_t;
  exp_t sbq[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference timer state, advanced from the spec rules on every rising edge.
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip;
  int          m_presc, cyc;
  logic        t_tk, t_acc;
  logic [63:0] t_bm, t_inc;

  function automatic logic [63:0] bytemask(input logic [7:0] m);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = {8{m[i]}};
    return r;
  endfunction

  assign t_tk  = (m_presc == TD - 1);
  assign t_bm  = bytemask(req_wmask);
  assign t_inc = m_mtime + (t_tk ? 64'd1 : 64'd0);
  assign t_acc = req_valid && req_ready && req_wen;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mtime <= '0; m_cmp <= '1; m_msip <= 1'b0; m_presc <= 0; cyc <= 0;
    end else begin
      m_presc <= t_tk ? 0 : m_presc + 1;
      cyc     <= cyc + 1;
      if (t_acc && req_addr == A_TIME) m_mtime <= (req_wdata & t_bm) | (t_inc & ~t_bm);
      else                             m_mtime <= t_inc;
      if (t_acc && req_addr == A_CMP)  m_cmp <= (req_wdata & t_bm) | (m_cmp & ~t_bm);
      if (t_acc && req_addr == A_MSIP && req_wmask[0]) m_msip <= req_wdata[0];
    end
  end

  function automatic logic [63:0] model_read(input logic [63:0] a);
    if (a == A_MSIP) return {63'b0, m_msip};
    if (a == A_CMP)  return m_cmp;
    if (a == A_TIME) return m_mtime;
    return '0;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("rst_req_ready", {63'b0, req_ready}, 64'd0);
      chk("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
      chk("rst_rdata", resp_rdata, 64'd0);
      chk("rst_err", {63'b0, resp_err}, 64'd0);
      chk("rst_msip", {63'b0, msip}, 64'd0);
      chk("rst_mtip", {63'b0, mtip}, 64'd0);
    end else begin
      chk("mtip", {63'b0, mtip}, {63'b0, (m_mtime >= m_cmp)});
      chk("msip", {63'b0, msip}, {63'b0, m_msip});
      if (resp_valid && resp_ready) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_resp actual=resp required=none");
        end else begin
          e = sbq.pop_front();
          chk({e.name, "_rdata"}, resp_rdata, e.rdata);
          chk({e.name, "_err"}, {63'b0, resp_err}, {63'b0, e.err});
        end
      end
    end
  end

  task automatic send(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [7:0] wmask, input string nm, input int mode,
                      input logic [63:0] xr, input logic xe);
    exp_t e;
    int n;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL %s_req_ready_timeout actual=0 required=1", nm);
      req_valid = 1'b0;
      return;
    end
    e.name = nm;
    if (mode == MDL) begin
      e.err   = !(addr == A_MSIP || addr == A_CMP || addr == A_TIME);
      e.rdata = (wen || e.err) ? 64'd0 : model_read(addr);
    end else if (mode == CYC) begin
      e.err = 1'b0; e.rdata = 64'(cyc);
    end else begin
      e.err = xe; e.rdata = xr;
    end
    sbq.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0; req_wen = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int n = 0; n < 50; n++) begin
      if (resp_valid && resp_ready) begin @(posedge clk); #1; return; end
      @(posedge clk); #1;
    end
    total++; bad++;
    $display("FAIL %s_resp_timeout actual=0 required=1", nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    send(1'b0, A_TIME, 0, 0, "rd_mtime_boot", CYC_MODE, 0, 0);       drain("rd_mtime_boot");
    send(1'b0, A_CMP, 0, 0, "rd_cmp_reset", EXPL, '1, 1'b0);         drain("rd_cmp_reset");
    send(1'b0, A_MSIP, 0, 0, "rd_msip_reset", EXPL, 0, 1'b0);        drain("rd_msip_reset");

    send(1'b1, A_CMP, 64'd100, 8'hFF, "wr_cmp100", EXPL, 0, 1'b0);  drain("wr_cmp100");
    n = 0;
    while (!mtip && n < 1000) begin @(posedge clk); #1; n++; end
    chk("mtip_rise_mtime", m_mtime, 64'd100);
    send(1'b1, A_CMP, '1, 8'hFF, "wr_cmp_max", EXPL, 0, 1'b0);      drain("wr_cmp_max");
    chk("mtip_clear", {63'b0, mtip}, 64'd0);

    send(1'b1, A_MSIP, 64'd1, 8'h01, "wr_msip1", EXPL, 0, 1'b0);    drain("wr_msip1");
    chk("msip_set", {63'b0, msip}, 64'd1);
    send(1'b0, A_MSIP, 0, 0, "rd_msip1", EXPL, 64'd1, 1'b0);         drain("rd_msip1");
    send(1'b1, A_MSIP, 64'd0, 8'hFF, "wr_msip0", EXPL, 0, 1'b0);    drain("wr_msip0");
    chk("msip_clr", {63'b0, msip}, 64'd0);
    send(1'b0, A_MSIP, 0, 0, "rd_msip0", EXPL, 64'd0, 1'b0);         drain("rd_msip0");
    send(1'b1, A_MSIP, 64'd1, 8'h00, "wr_msip_nomask", EXPL, 0, 1'b0); drain("wr_msip_nomask");
    chk("msip_nomask", {63'b0, msip}, 64'd0);

    send(1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, "wr_time_wrap", EXPL, 0, 1'b0);
    drain("wr_time_wrap");
    if (TD == 1) begin
      send(1'b0, A_TIME, 0, 0, "rd_time_ff", EXPL, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0); drain("rd_time_ff");
      send(1'b0, A_TIME, 0, 0, "rd_time_wrapped", EXPL, 64'd1, 1'b0);             drain("rd_time_wrapped");
    end else begin
      send(1'b0, A_TIME, 0, 0, "rd_time_ff", MDL, 0, 0);      drain("rd_time_ff");
      repeat (8) @(posedge clk); #1;
      send(1'b0, A_TIME, 0, 0, "rd_time_wrapped", MDL, 0, 0); drain("rd_time_wrapped");
    end
    send(1'b1, A_TIME, 64'h1122_3344_5566_7700, 8'hFF, "wr_time_full", EXPL, 0, 1'b0); drain("wr_time_full");
    send(1'b1, A_TIME, 64'h0000_0000_0000_0055, 8'h01, "wr_time_b0", EXPL, 0, 1'b0);   drain("wr_time_b0");
    send(1'b0, A_TIME, 0, 0, "rd_time_b0", MDL, 0, 0);                                drain("rd_time_b0");
    send(1'b1, A_CMP, 64'h0000_0000_0000_0055, 8'h01, "wr_cmp_b0", EXPL, 0, 1'b0);     drain("wr_cmp_b0");
    send(1'b0, A_CMP, 0, 0, "rd_cmp_b0", EXPL, 64'hFFFF_FFFF_FFFF_FF55, 1'b0);          drain("rd_cmp_b0");
    send(1'b1, A_CMP, 64'd0, 8'h00, "wr_cmp_nomask", EXPL, 0, 1'b0);                   drain("wr_cmp_nomask");
    send(1'b0, A_CMP, 0, 0, "rd_cmp_nomask", EXPL, 64'hFFFF_FFFF_FFFF_FF55, 1'b0);      drain("rd_cmp_nomask");

    resp_ready = 1'b0;
    send(1'b0, BASE + 64'h1000, 0, 0, "rd_unmapped", EXPL, 64'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_resp_valid", {63'b0, resp_valid}, 64'd1);
      chk("stall_req_ready", {63'b0, req_ready}, 64'd0);
      chk("stall_rdata", resp_rdata, 64'd0);
      chk("stall_err", {63'b0, resp_err}, 64'd1);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    drain("rd_unmapped");
    send(1'b1, BASE + 64'h8, '1, 8'hFF, "wr_unmapped", EXPL, 64'd0, 1'b1);        drain("wr_unmapped");
    send(1'b0, A_MSIP, 0, 0, "rd_msip_after_err", EXPL, 64'd0, 1'b0);             drain("rd_msip_after_err");
    send(1'b0, A_CMP, 0, 0, "rd_cmp_after_err", EXPL, 64'hFFFF_FFFF_FFFF_FF55, 1'b0); drain("rd_cmp_after_err");

    resp_ready = 1'b0;
    send(1'b0, A_CMP, 0, 0, "rd_dropped", EXPL, 64'hFFFF_FFFF_FFFF_FF55, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("midrst_resp_valid", {63'b0, resp_valid}, 64'd0);
    chk("midrst_req_ready", {63'b0, req_ready}, 64'd0);
    chk("midrst_rdata", resp_rdata, 64'd0);
    sbq.delete();
    resp_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    repeat (4) @(posedge clk); #1;
    send(1'b0, A_TIME, 0, 0, "rd_mtime_rst2", CYC_MODE, 0, 0); drain("rd_mtime_rst2");
    send(1'b0, A_CMP, 0, 0, "rd_cmp_rst2", EXPL, '1, 1'b0);    drain("rd_cmp_rst2");

    repeat (3) @(posedge clk); #1;
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
